// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs, fetch handshake and stall/flush controls between the
// sequencing controller and the CPU datapath.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       RsD;
    logic [4:0]       RtD;
    logic [4:0]       RtE;
    logic [4:0]       WriteRegE;
    logic [4:0]       WriteRegM;
    logic             MemtoRegE;
    logic             RegWriteE;
    logic             MemtoRegM;
    logic             BranchD;
    logic             PCSrcD;
    logic             IMemAck;
    logic             IMemReq;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    logic             FetchTimeout;
    logic [CNT_W-1:0] StallCount;
    logic [CNT_W-1:0] FlushCount;

    // Controller side: observes the pipeline, drives the stage controls.
    modport master (
        input  RsD, RtD, RtE, WriteRegE, WriteRegM,
        input  MemtoRegE, RegWriteE, MemtoRegM, BranchD, PCSrcD, IMemAck,
        output IMemReq, StallF, StallD, FlushD, FlushE, FetchTimeout,
        output StallCount, FlushCount
    );

    // Datapath side: supplies pipeline state, consumes the stage controls.
    modport slave (
        output RsD, RtD, RtE, WriteRegE, WriteRegM,
        output MemtoRegE, RegWriteE, MemtoRegM, BranchD, PCSrcD, IMemAck,
        input  IMemReq, StallF, StallD, FlushD, FlushE, FetchTimeout,
        input  StallCount, FlushCount
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Count one per cycle with inc high, holding once every bit is set.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: boot hold, instruction fetch handshake,
// load-use and branch-operand hazard stalls, branch flush and statistics.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int TIMEOUT     = 16,
    parameter int CNT_W       = 32
) (
    input  logic            CLK,
    input  logic            RST,
    pipeline_ctrl_if.master bus
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

    state_t            state;
    state_t            next_state;
    logic [BOOT_W-1:0] boot_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              fetch_timeout;
    logic              boot_done;
    logic              fetch_active;
    logic              fetch_miss;
    logic              lw_stall;
    logic              branch_stall;
    logic              hazard_stall;
    logic              imem_req;
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              flush_e;

    // A load in Execute whose target feeds the Decode instruction must wait
    // one cycle; register 0 is never a real dependency.
    assign lw_stall = bus.MemtoRegE && (bus.RtE != REG_ZERO) &&
                      ((bus.RtE == bus.RsD) || (bus.RtE == bus.RtD));

    // Branches compare in Decode, so an operand still being produced in
    // Execute (ALU) or Memory (load) has not reached a forwarding point.
    assign branch_stall = bus.BranchD &&
        ((bus.RegWriteE && (bus.WriteRegE != REG_ZERO) &&
          ((bus.WriteRegE == bus.RsD) || (bus.WriteRegE == bus.RtD))) ||
         (bus.MemtoRegM && (bus.WriteRegM != REG_ZERO) &&
          ((bus.WriteRegM == bus.RsD) || (bus.WriteRegM == bus.RtD))));

    assign hazard_stall = lw_stall || branch_stall;
    assign boot_done    = (state == BOOT) && (boot_cnt == BOOT_LAST);
    assign fetch_active = (state == RUN) || (state == WAIT);
    assign fetch_miss   = fetch_active && !bus.IMemAck;

    // Controller state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= BOOT;
        end else begin
            state <= next_state;
        end
    end

    // Count edges spent in BOOT so the PC is held for a fixed number of cycles.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            boot_cnt <= '0;
        end else if ((state == BOOT) && !boot_done) begin
            boot_cnt <= boot_cnt + BOOT_W'(1);
        end else begin
            boot_cnt <= '0;
        end
    end

    // Track consecutive un-acked fetch cycles; an ack clears the run and
    // wins over reaching the limit in the same cycle. The timeout is sticky.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wait_cnt      <= '0;
            fetch_timeout <= 1'b0;
        end else if (!fetch_miss) begin
            wait_cnt <= '0;
        end else begin
            if (wait_cnt != WAIT_MAX) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            if (wait_cnt == WAIT_LAST) begin
                fetch_timeout <= 1'b1;
            end
        end
    end

    // Next state and stage controls; BOOT holds everything, a missing fetch
    // freezes the front end, otherwise hazards stall and taken branches flush.
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        stall_f    = 1'b1;
        stall_d    = 1'b1;
        flush_d    = 1'b1;
        flush_e    = 1'b1;
        case (state)
            BOOT: begin
                if (boot_done) begin
                    next_state = RUN;
                end
            end
            RUN, WAIT: begin
                imem_req = 1'b1;
                if (!bus.IMemAck) begin
                    stall_f    = 1'b1;
                    stall_d    = 1'b1;
                    flush_e    = 1'b1;
                    flush_d    = 1'b0;
                    next_state = WAIT;
                end else begin
                    stall_f    = hazard_stall;
                    stall_d    = hazard_stall;
                    flush_e    = hazard_stall;
                    flush_d    = bus.PCSrcD && !hazard_stall;
                    next_state = RUN;
                end
            end
            default: begin
                next_state = BOOT;
            end
        endcase
    end

    assign bus.IMemReq      = imem_req;
    assign bus.StallF       = stall_f;
    assign bus.StallD       = stall_d;
    assign bus.FlushD       = flush_d;
    assign bus.FlushE       = flush_e;
    assign bus.FetchTimeout = fetch_timeout;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (fetch_active && stall_f),
        .count (bus.StallCount)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (fetch_active && flush_d),
        .count (bus.FlushCount)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl, plus a narrow-counter copy
// that is starved of fetch acks to exercise counter saturation.
module tb_pipeline_ctrl;

    localparam int TIMEOUT_TB = 16;

    typedef struct {
        logic [4:0] rsD;
        logic [4:0] rtD;
        logic [4:0] rtE;
        logic [4:0] writeRegE;
        logic [4:0] writeRegM;
        logic       memtoRegE;
        logic       regWriteE;
        logic       memtoRegM;
        logic       branchD;
        logic       pcSrcD;
        logic       imemAck;
    } stim_t;

    typedef struct {
        string       tag;
        logic        imemReq;
        logic        stallF;
        logic        stallD;
        logic        flushD;
        logic        flushE;
        logic        fetchTimeout;
        logic [31:0] stallCount;
        logic [31:0] flushCount;
    } exp_t;

    logic  CLK = 1'b0;
    logic  RST = 1'b1;
    int    vectorCount = 0;
    int    missCount = 0;
    int    modelStall = 0;
    int    modelFlush = 0;
    int    modelWait = 0;
    logic  modelTimeout = 1'b0;
    exp_t  expQ[$];
    stim_t s;

    pipeline_ctrl_if #(.CNT_W(32)) cif ();
    pipeline_ctrl_if #(.CNT_W(4))  satIf ();

    pipeline_ctrl #(.BOOT_CYCLES(2), .TIMEOUT(TIMEOUT_TB), .CNT_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (cif)
    );

    pipeline_ctrl #(.BOOT_CYCLES(2), .TIMEOUT(TIMEOUT_TB), .CNT_W(4)) dutSat (
        .CLK (CLK),
        .RST (RST),
        .bus (satIf)
    );

    // Free-running clock, 10 time units per period.
    always #5 CLK = ~CLK;

    function automatic stim_t idleStim();
        stim_t t;
        t.rsD = 5'd0;  t.rtD = 5'd0;  t.rtE = 5'd0;
        t.writeRegE = 5'd0;  t.writeRegM = 5'd0;
        t.memtoRegE = 1'b0;  t.regWriteE = 1'b0;  t.memtoRegM = 1'b0;
        t.branchD = 1'b0;  t.pcSrcD = 1'b0;  t.imemAck = 1'b1;
        return t;
    endfunction

    function automatic exp_t mkExp(string tag, logic req, logic sf, logic sd,
                                   logic fd, logic fe);
        exp_t e;
        e.tag = tag;  e.imemReq = req;
        e.stallF = sf;  e.stallD = sd;  e.flushD = fd;  e.flushE = fe;
        e.fetchTimeout = 1'b0;  e.stallCount = '0;  e.flushCount = '0;
        return e;
    endfunction

    function automatic exp_t expBoot(string tag);
        return mkExp(tag, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    endfunction

    function automatic exp_t expWait(string tag);
        return mkExp(tag, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    endfunction

    function automatic exp_t expRun(string tag, logic stall, logic flush);
        return mkExp(tag, 1'b1, stall, stall, flush, stall);
    endfunction

    task automatic compare(input string tag, input string field,
                           input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        assert (obs === exp) else begin
            missCount++;
            $error("[TB] FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(negedge CLK);
    endtask

    task automatic applyStimulus(input stim_t st, input exp_t e);
        cif.RsD       = st.rsD;
        cif.RtD       = st.rtD;
        cif.RtE       = st.rtE;
        cif.WriteRegE = st.writeRegE;
        cif.WriteRegM = st.writeRegM;
        cif.MemtoRegE = st.memtoRegE;
        cif.RegWriteE = st.regWriteE;
        cif.MemtoRegM = st.memtoRegM;
        cif.BranchD   = st.branchD;
        cif.PCSrcD    = st.pcSrcD;
        cif.IMemAck   = st.imemAck;
        e.stallCount   = 32'(modelStall);
        e.flushCount   = 32'(modelFlush);
        e.fetchTimeout = modelTimeout;
        expQ.push_back(e);
        if (e.imemReq) begin
            if (e.stallF) modelStall++;
            if (e.flushD) modelFlush++;
            if (st.imemAck) begin
                modelWait = 0;
            end else begin
                modelWait++;
                if (modelWait == TIMEOUT_TB) modelTimeout = 1'b1;
            end
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        #1;
        if (expQ.size() == 0) begin
            vectorCount++;
            missCount++;
            $error("[TB] FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = expQ.pop_front();
        compare(e.tag, "IMemReq",      32'(cif.IMemReq),      32'(e.imemReq));
        compare(e.tag, "StallF",       32'(cif.StallF),       32'(e.stallF));
        compare(e.tag, "StallD",       32'(cif.StallD),       32'(e.stallD));
        compare(e.tag, "FlushD",       32'(cif.FlushD),       32'(e.flushD));
        compare(e.tag, "FlushE",       32'(cif.FlushE),       32'(e.flushE));
        compare(e.tag, "FetchTimeout", 32'(cif.FetchTimeout), 32'(e.fetchTimeout));
        compare(e.tag, "StallCount",   cif.StallCount,        e.stallCount);
        compare(e.tag, "FlushCount",   cif.FlushCount,        e.flushCount);
    endtask

    task automatic runStep(input stim_t st, input exp_t e);
        nextCycle();
        applyStimulus(st, e);
        checkOutput();
    endtask

    // Directed sequence: reset, boot, hazards, fetch waits, saturation, reset.
    initial begin
        satIf.RsD = 5'd0;  satIf.RtD = 5'd0;  satIf.RtE = 5'd0;
        satIf.WriteRegE = 5'd0;  satIf.WriteRegM = 5'd0;
        satIf.MemtoRegE = 1'b0;  satIf.RegWriteE = 1'b0;  satIf.MemtoRegM = 1'b0;
        satIf.BranchD = 1'b0;  satIf.PCSrcD = 1'b0;  satIf.IMemAck = 1'b0;

        $display("[TB] reset and boot");
        runStep(idleStim(), expBoot("in_reset"));

        nextCycle();
        RST = 1'b0;
        applyStimulus(idleStim(), expBoot("boot0"));
        checkOutput();
        runStep(idleStim(), expBoot("boot1"));
        runStep(idleStim(), expRun("run0", 1'b0, 1'b0));
        compare("sat_run0", "StallCount", 32'(satIf.StallCount), 32'd0);
        compare("sat_run0", "StallF", 32'(satIf.StallF), 32'd1);
        runStep(idleStim(), expRun("run1", 1'b0, 1'b0));
        compare("sat_run1", "StallCount", 32'(satIf.StallCount), 32'd1);

        $display("[TB] load-use hazards");
        s = idleStim(); s.memtoRegE = 1'b1; s.regWriteE = 1'b1;
        s.rtE = 5'd5; s.writeRegE = 5'd5; s.rsD = 5'd5;
        runStep(s, expRun("lw_use", 1'b1, 1'b0));
        runStep(idleStim(), expRun("lw_bubble", 1'b0, 1'b0));
        s = idleStim(); s.memtoRegE = 1'b1; s.rtE = 5'd0; s.rsD = 5'd0;
        runStep(s, expRun("lw_r0", 1'b0, 1'b0));
        s = idleStim(); s.memtoRegE = 1'b1; s.rtE = 5'd7; s.rtD = 5'd7; s.rsD = 5'd3;
        runStep(s, expRun("lw_rtd", 1'b1, 1'b0));
        runStep(idleStim(), expRun("lw_done", 1'b0, 1'b0));

        $display("[TB] branch hazards");
        s = idleStim(); s.branchD = 1'b1; s.rsD = 5'd8; s.memtoRegE = 1'b1;
        s.regWriteE = 1'b1; s.rtE = 5'd8; s.writeRegE = 5'd8;
        runStep(s, expRun("br_lwE", 1'b1, 1'b0));
        s = idleStim(); s.branchD = 1'b1; s.rsD = 5'd8; s.memtoRegM = 1'b1; s.writeRegM = 5'd8;
        runStep(s, expRun("br_lwM", 1'b1, 1'b0));
        s = idleStim(); s.branchD = 1'b1; s.rsD = 5'd8; s.pcSrcD = 1'b1;
        runStep(s, expRun("br_taken", 1'b0, 1'b1));
        runStep(idleStim(), expRun("br_after", 1'b0, 1'b0));
        s = idleStim(); s.branchD = 1'b1; s.rtD = 5'd9; s.regWriteE = 1'b1;
        s.writeRegE = 5'd9; s.pcSrcD = 1'b1;
        runStep(s, expRun("br_aluE", 1'b1, 1'b0));
        s = idleStim(); s.branchD = 1'b1; s.rtD = 5'd9; s.pcSrcD = 1'b1;
        runStep(s, expRun("br_alu_go", 1'b0, 1'b1));
        s = idleStim(); s.branchD = 1'b1; s.regWriteE = 1'b1; s.writeRegE = 5'd0;
        s.memtoRegM = 1'b1; s.writeRegM = 5'd0;
        runStep(s, expRun("br_r0", 1'b0, 1'b0));
        s = idleStim(); s.regWriteE = 1'b1; s.writeRegE = 5'd3; s.rsD = 5'd3;
        runStep(s, expRun("alu_nobr", 1'b0, 1'b0));

        $display("[TB] fetch waits");
        s = idleStim(); s.imemAck = 1'b0; s.pcSrcD = 1'b1;
        runStep(s, expWait("wait_flush"));
        s = idleStim(); s.imemAck = 1'b0;
        runStep(s, expWait("wait_a1"));
        runStep(s, expWait("wait_a2"));
        runStep(idleStim(), expRun("wait_a_ack", 1'b0, 1'b0));
        for (int i = 0; i < TIMEOUT_TB - 1; i++) begin
            runStep(s, expWait($sformatf("wait_b%0d", i)));
        end
        s = idleStim(); s.memtoRegE = 1'b1; s.rtE = 5'd4; s.rsD = 5'd4;
        runStep(s, expRun("ack_at_limit", 1'b1, 1'b0));
        s = idleStim(); s.imemAck = 1'b0;
        for (int i = 0; i < TIMEOUT_TB; i++) begin
            runStep(s, expWait($sformatf("wait_c%0d", i)));
        end
        runStep(idleStim(), expRun("to_ack", 1'b0, 1'b0));
        runStep(idleStim(), expRun("to_sticky", 1'b0, 1'b0));

        compare("sat", "StallCount", 32'(satIf.StallCount), 32'd15);
        compare("sat", "FlushCount", 32'(satIf.FlushCount), 32'd0);
        compare("sat", "FetchTimeout", 32'(satIf.FetchTimeout), 32'd1);
        compare("sat", "IMemReq", 32'(satIf.IMemReq), 32'd1);

        $display("[TB] reset during fetch wait");
        s = idleStim(); s.imemAck = 1'b0;
        runStep(s, expWait("pre_rst0"));
        runStep(s, expWait("pre_rst1"));
        #2;
        RST = 1'b1;
        modelStall = 0;
        modelFlush = 0;
        modelWait = 0;
        modelTimeout = 1'b0;
        applyStimulus(s, expBoot("rst_mid"));
        checkOutput();
        compare("sat_rst", "StallCount", 32'(satIf.StallCount), 32'd0);
        compare("sat_rst", "FetchTimeout", 32'(satIf.FetchTimeout), 32'd0);

        nextCycle();
        RST = 1'b0;
        applyStimulus(idleStim(), expBoot("reboot0"));
        checkOutput();
        runStep(idleStim(), expBoot("reboot1"));
        runStep(idleStim(), expRun("rerun0", 1'b0, 1'b0));
        s = idleStim(); s.branchD = 1'b1; s.rsD = 5'd6; s.pcSrcD = 1'b1;
        runStep(s, expRun("rerun_br", 1'b0, 1'b1));
        runStep(idleStim(), expRun("rerun1", 1'b0, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Pipeline sequencing controller for the 5-stage CPU. It generates the stall and flush controls for the fetch PC register (the WB/IF register), the IF/ID register and the ID/EX register. It runs a post-reset boot hold and an instruction-memory fetch handshake, and resolves load-use and branch-operand hazards. It also keeps saturating stall and flush statistics counters.

## Interface
Parameters:
- BOOT_CYCLES, 2: cycles the PC is held after reset release (≥1)
- TIMEOUT, 16: consecutive un-acked fetch cycles before FetchTimeout sets
- CNT_W, 32: statistics counter width

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  asynchronous, active-high reset
- RsD, RtD  in  5  source registers of the instruction in Decode
- RtE, WriteRegE  in  5  Execute-stage Rt / destination register
- MemtoRegE, RegWriteE  in  1  Execute-stage load / register-write flags
- WriteRegM  in  5  Memory-stage destination register
- MemtoRegM  in  1  Memory-stage load flag
- BranchD, PCSrcD  in  1  Decode-stage branch present / branch taken
- IMemAck  in  1  instruction word at PCF valid this cycle
- IMemReq  out  1  fetch request
- StallF  out  1  to PC register enable; 1 = hold PCF
- StallD  out  1  hold IF/ID
- FlushD  out  1  clear IF/ID
- FlushE  out  1  insert bubble into ID/EX
- FetchTimeout  out  1  sticky fetch-timeout flag
- StallCount, FlushCount  out  CNT_W  saturating statistics

## Operation
- States: BOOT, RUN, WAIT.
- BOOT (reset state):
  - StallF = StallD = FlushD = FlushE = 1, IMemReq = 0.
  - A boot counter counts BOOT_CYCLES rising edges after RST falls, then the block moves to RUN.
- RUN:
  - IMemReq = 1.
  - If IMemAck = 0: StallF = StallD = FlushE = 1, FlushD = 0. Next state is WAIT.
  - If IMemAck = 1: apply the hazard logic below. Next state stays RUN.
- WAIT:
  - IMemReq = 1. Outputs as for RUN with IMemAck = 0.
  - On IMemAck = 1: the hazard logic applies in that same cycle, and the next state is RUN.
  - A wait counter counts consecutive un-acked cycles. When it reaches TIMEOUT, FetchTimeout sets and stays set until RST. The block keeps waiting.
- Hazard logic (fetch acked):
  - lwstall = MemtoRegE & RtE≠0 & (RtE==RsD | RtE==RtD).
  - branchstall = BranchD & [(RegWriteE & WriteRegE≠0 & (WriteRegE==RsD | WriteRegE==RtD)) | (MemtoRegM & WriteRegM≠0 & (WriteRegM==RsD | WriteRegM==RtD))].
  - StallF = StallD = FlushE = lwstall | branchstall.
  - FlushD = PCSrcD & ~StallD.
- Priority: BOOT > fetch wait > data hazard stall > branch flush.
- Counters (outside BOOT only):
  - StallCount increments every cycle StallF = 1.
  - FlushCount increments every cycle FlushD = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- Stall and flush outputs are combinational from state and current inputs. The stage registers act on them at the next rising CLK.
- Load-use stall is exactly 1 cycle: the E bubble clears MemtoRegE.
- Branch stall lasts 1 cycle for an ALU producer and 2 cycles for a load producer.
- IMemReq stays high from RUN entry until ack; there is no gap between back-to-back fetches. StallF falls in the ack cycle.
- Reset values:
  - state = BOOT, so StallF = StallD = FlushD = FlushE = 1.
  - IMemReq = 0, FetchTimeout = 0, StallCount = FlushCount = 0.
  - Boot counter and wait counter = 0.
- Reset mid-operation: all outputs take their reset values immediately, independent of CLK, and the boot sequence restarts on release.
- Register 0 never causes a hazard.
- Wait counter clears on ack. Simultaneous ack and timeout-reach: the ack wins and FetchTimeout does not set.

## Structure
- Package pipeline_ctrl_pkg holds:
  - the state enumeration (BOOT, RUN, WAIT);
  - the constant REG_ZERO = 5'd0.
- Sub-module sat_counter (parameter CNT_W; ports CLK, RST, inc, count), instantiated twice for the statistics counters.
- Hazard comparisons stay inline.

## Test plan
- Reset released, IMemAck = 1 → StallF = 1 for exactly 2 cycles (BOOT_CYCLES = 2), then 0; IMemReq rises the cycle state enters RUN.
- Load in E with RtE = 5, RsD = 5 → StallF = StallD = FlushE = 1 for one cycle; StallCount +1. Repeat with RtE = 0 → no stall.
- BranchD = 1, RsD = 8, MemtoRegE = 1 with RtE = WriteRegE = 8 → 1-cycle load-use stall, then 1 cycle with MemtoRegM = 1 & WriteRegM = 8 → second stall; 2 stall cycles total. Then PCSrcD = 1 → FlushD = 1 for one cycle; FlushCount +1.
- IMemAck held 0 for 16 cycles → StallF = 1 throughout; FetchTimeout sets after the 16th un-acked cycle and stays 1 after a later ack.
- Preload StallCount to near all-ones via a forced long fetch wait (CNT_W = 4) → StallCount saturates at 15.
- RST asserted mid-WAIT → all outputs at reset values within the same cycle; BOOT repeats on release.
